// File: rtl/piso_buf_256b_ctrl.sv
// Parallel-in/serial-out scan feed buffer: 64 x 32b FIFO plus an LSB-first shift-out engine.
// Optional macro PISO_PARITY_EN appends an even-parity bit after each shifted word.
module piso_buf_256b_ctrl #(
  parameter int DW    = 32,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          val_op,
  input  logic          op,
  input  logic [DW-1:0] wdata,
  input  logic          addrclr,
  output logic          op_ack,
  output logic          op_commit,
  output logic          op_err,
  output logic          sout,
  output logic          sout_val,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int CW = $clog2(DW + 1);
`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] LAST = CW'(DW);
`else
  localparam logic [CW-1:0] LAST = CW'(DW - 1);
`endif

  typedef enum logic [2:0] {IDLE, MEMW, MEMR, LOAD, SEOUT, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic [CW-1:0] bit_q;
  logic [DW-1:0] sreg_q, wdata_q, rdata_q;
  logic          err_q;
  logic          accept_wr, accept_rd, reject;
  logic [DW-1:0] mem [DEPTH];
`ifdef PISO_PARITY_EN
  logic          par_q;
`endif

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign accept_wr = (state_q == IDLE) && val_op && !op && !full;
  assign accept_rd = (state_q == IDLE) && val_op &&  op && !empty;
  assign reject    = (state_q == IDLE) && val_op && (op ? empty : full);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_wr) state_d = MEMW;
               else if (accept_rd) state_d = MEMR;
      MEMW:    state_d = IDLE;
      MEMR:    state_d = LOAD;
      LOAD:    state_d = SEOUT;
      SEOUT:   if (bit_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign op_ack    = (state_q == MEMW) || (state_q == MEMR);
  assign op_commit = (state_q == MEMW) || (state_q == DONE);
  assign op_err    = err_q;
  assign busy      = (state_q != IDLE);
  assign sout_val  = (state_q == SEOUT);
`ifdef PISO_PARITY_EN
  assign sout = sout_val && ((bit_q == LAST) ? par_q : sreg_q[0]);
`else
  assign sout = sout_val && sreg_q[0];
`endif

  // Storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (state_q == MEMW) mem[wptr_q] <= wdata_q;
    if (state_q == MEMR) rdata_q     <= mem[rptr_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      err_q <= reject;
      case (state_q)
        IDLE: begin
          if (accept_wr) wdata_q <= wdata;
          // a simultaneous op takes priority over the clear
          if (addrclr && !val_op) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
          end
        end
        MEMW: begin
          wptr_q <= wptr_q + 1'b1;
          cnt_q  <= cnt_q + 1'b1;
        end
        LOAD: begin
          sreg_q <= rdata_q;
          rptr_q <= rptr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
          bit_q  <= '0;
`ifdef PISO_PARITY_EN
          par_q  <= ^rdata_q;
`endif
        end
        SEOUT: begin
          sreg_q <= sreg_q >> 1;
          bit_q  <= bit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_buf_256b_ctrl.sv
// Self-checking bench for piso_buf_256b_ctrl: vector table, directed corners, random ops vs a queue model.
module tb_piso_buf_256b_ctrl;
  localparam int DW = 32, DEPTH = 64, AW = 6;
`ifdef PISO_PARITY_EN
  localparam int RD_LAT = 36, NBITS = 33;
`else
  localparam int RD_LAT = 35, NBITS = 32;
`endif

  logic          clk = 0, reset_n = 0, val_op = 0, op = 0, addrclr = 0;
  logic [DW-1:0] wdata = '0;
  logic          op_ack, op_commit, op_err, sout, sout_val, busy, full, empty;
  logic [AW:0]   count;

  piso_buf_256b_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .val_op(val_op), .op(op), .wdata(wdata),
    .addrclr(addrclr), .op_ack(op_ack), .op_commit(op_commit), .op_err(op_err),
    .sout(sout), .sout_val(sout_val), .busy(busy), .full(full), .empty(empty),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] mq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Caller is at a negedge. Issues one op and observes until commit or reject.
  task automatic do_op(input logic o, input logic [DW-1:0] d, output logic ack, output logic err,
                       output int lat, output logic [32:0] bits, output int nb, output int bad);
    val_op = 1; op = o; wdata = d;
    @(negedge clk);
    val_op = 0; wdata = $urandom;
    ack = 0; err = 0; lat = 0; bits = '0; nb = 0; bad = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) begin ack = op_ack; err = op_err; end
      if (sout_val) begin
        if (nb < 33) bits[nb] = sout;
        nb++;
      end else if (sout !== 1'b0) bad++;
      if (op_commit) begin lat = k; break; end
      if (k == 1 && !busy) break;
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_count"}, 64'(count), 64'(mq.size()));
    check({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
    check({tag, "_full"},  64'(full),  64'(mq.size() == DEPTH));
  endtask

  // Model-checked op; returns at the negedge of the cycle after commit/reject.
  task automatic run_op(input logic o, input logic [DW-1:0] d, input string tag);
    logic ack, err, exp_err;
    int lat, nb, bad;
    logic [32:0] bits;
    logic [DW-1:0] w;
    exp_err = o ? (mq.size() == 0) : (mq.size() == DEPTH);
    do_op(o, d, ack, err, lat, bits, nb, bad);
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    check({tag, "_ack"}, 64'(ack), 64'(!exp_err));
    if (!exp_err) begin
      check({tag, "_lat"}, 64'(lat), 64'(o ? RD_LAT : 1));
      if (o) begin
        w = mq.pop_front();
        check({tag, "_rdata"}, 64'(bits[31:0]), 64'(w));
        check({tag, "_nbits"}, 64'(nb), 64'(NBITS));
        check({tag, "_sout_idle"}, 64'(bad), 64'd0);
`ifdef PISO_PARITY_EN
        check({tag, "_parity"}, 64'(bits[32]), 64'(^w));
`endif
      end else mq.push_back(d);
    end
    @(negedge clk);
    check_flags(tag);
  endtask

  typedef struct {
    logic          o;
    logic [DW-1:0] d;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            exp_cnt;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic ack, err;
    int lat, nb, bad;
    logic [32:0] bits;

    tbl[0] = '{1'b1, 32'h0,        1'b1, 32'h0,        0};
    tbl[1] = '{1'b0, 32'hA5A50001, 1'b0, 32'h0,        1};
    tbl[2] = '{1'b1, 32'h0,        1'b0, 32'hA5A50001, 0};
    tbl[3] = '{1'b0, 32'h00000007, 1'b0, 32'h0,        1};
    tbl[4] = '{1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        2};
    tbl[5] = '{1'b1, 32'h0,        1'b0, 32'h00000007, 1};
    tbl[6] = '{1'b1, 32'h0,        1'b0, 32'hDEADBEEF, 0};
    tbl[7] = '{1'b1, 32'h0,        1'b1, 32'h0,        0};
    tbl[8] = '{1'b0, 32'hFFFFFFFF, 1'b0, 32'h0,        1};
    tbl[9] = '{1'b1, 32'h0,        1'b0, 32'hFFFFFFFF, 0};

    // reset state
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_outs", 64'({op_ack, op_commit, op_err, sout, sout_val}), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].o, tbl[i].d, ack, err, lat, bits, nb, bad);
      check($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
      check($sformatf("vec%0d_ack", i), 64'(ack), 64'(!tbl[i].exp_err));
      if (!tbl[i].exp_err) begin
        check($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].o ? RD_LAT : 1));
        if (tbl[i].o) begin
          check($sformatf("vec%0d_rd", i), 64'(bits[31:0]), 64'(tbl[i].exp_rd));
          check($sformatf("vec%0d_sidle", i), 64'(bad), 64'd0);
`ifdef PISO_PARITY_EN
          check($sformatf("vec%0d_par", i), 64'(bits[32]), 64'(^tbl[i].exp_rd));
`endif
        end
      end
      @(negedge clk);
      check($sformatf("vec%0d_cnt", i), 64'(count), 64'(tbl[i].exp_cnt));
      check($sformatf("vec%0d_empty", i), 64'(empty), 64'(tbl[i].exp_cnt == 0));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
    end

    // fill to full, overflow reject, drain in order
    for (int i = 0; i < DEPTH; i++) run_op(1'b0, DW'(i), "fill");
    run_op(1'b0, 32'h12345678, "overflow");
    for (int i = 0; i < DEPTH; i++) run_op(1'b1, '0, "drain");

    // pointer wrap across 63 -> 0
    for (int i = 0; i < 60; i++) run_op(1'b0, $urandom, "wrapw");
    for (int i = 0; i < 60; i++) run_op(1'b1, '0, "wrapr");
    for (int i = 0; i < 10; i++) run_op(1'b0, $urandom, "wrapw2");
    for (int i = 0; i < 10; i++) run_op(1'b1, '0, "wrapr2");

    // addrclr alone clears; addrclr alongside an op is ignored
    for (int i = 0; i < 3; i++) run_op(1'b0, $urandom, "clrw");
    addrclr = 1;
    @(negedge clk);
    addrclr = 0;
    mq.delete();
    @(negedge clk);
    check_flags("clr");
    addrclr = 1;
    run_op(1'b0, 32'hCAFE0001, "clr_opwins");
    addrclr = 0;
    run_op(1'b1, '0, "clr_opwins_rd");

    // reset during the 10th shift cycle aborts with no commit
    run_op(1'b0, 32'h5A5A5A5A, "abortw");
    val_op = 1; op = 1;
    @(negedge clk);
    val_op = 0;
    repeat (11) @(negedge clk);
    check("abort_sval_before", 64'(sout_val), 64'd1);
    #2 reset_n = 0;
    #1;
    check("abort_sval", 64'(sout_val), 64'd0);
    check("abort_sout", 64'(sout), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    begin
      int commits = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (op_commit) commits++;
      end
      reset_n = 1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (op_commit) commits++;
      end
      check("abort_nocommit", 64'(commits), 64'd0);
    end
    mq.delete();
    check_flags("abort");

    // random ops against the queue model
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        addrclr = 1;
        @(negedge clk);
        addrclr = 0;
        mq.delete();
        @(negedge clk);
        check_flags("rnd_clr");
      end else
        run_op(r < ((i < 125) ? 75 : 35) ? 1'b0 : 1'b1, $urandom, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
